// File: rtl/canvas_mem_arbiter.sv
// canvas_mem_arbiter: shares one synchronous single-port canvas RAM between the
// scan-out reader, the brush painter and an optional whole-canvas clear.
// Arbitration per edge: read, then clear, then paint. One RAM operation per cycle.
// Optional clear sequencer: define CANVAS_CLEAR_EN to build it.
module canvas_mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              pt_req,
    input  logic [ADDR_W-1:0] pt_addr,
    input  logic [DATA_W-1:0] pt_colour,
    input  logic              pt_enable,
    output logic              pt_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // RAM command registers
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Paint handshake
    logic              pt_ack_q, pt_ack_d;

    // Read pipeline: issued -> RAM access done -> data captured
    logic              rd_issue_q, rd_issue_d;
    logic              rd_wait_q, rd_wait_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Hooks from the clear sequencer into the arbiter
    logic              clr_active_c;
    logic              pt_allow_c;
    logic [ADDR_W-1:0] clr_addr_c;

`ifdef CANVAS_CLEAR_EN
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_busy_q, clr_busy_d;

    assign clr_active_c = (state_q == ST_CLEAR);
    assign pt_allow_c   = (state_q == ST_IDLE) && !clr_start;
    assign clr_addr_c   = cnt_q;
    assign clr_busy     = clr_busy_q;

    // Clear FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear address counter and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    // Clear FSM next state; the counter advances only on edges not stolen by a read
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!rd_req) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        clr_busy_d = (state_d == ST_CLEAR);
    end
`else
    logic unused_clr_start;

    assign unused_clr_start = clr_start;
    assign clr_active_c     = 1'b0;
    assign pt_allow_c       = 1'b1;
    assign clr_addr_c       = '0;
    assign clr_busy         = 1'b0;
`endif

    // Arbitration: pick at most one RAM operation for the next cycle
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pt_ack_d    = 1'b0;
        rd_issue_d  = rd_req;
        rd_wait_d   = rd_issue_q;
        rd_valid_d  = rd_wait_q;
        rd_data_d   = rd_wait_q ? mem_rdata : rd_data_q;

        if (rd_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = rd_addr;
        end else if (clr_active_c) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = clr_addr_c;
            mem_wdata_d = '0;
        end else if (pt_req && pt_allow_c && !pt_ack_q) begin
            // A grant with pt_enable low is a cursor move: ack without a write
            pt_ack_d = 1'b1;
            if (pt_enable) begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = pt_addr;
                mem_wdata_d = pt_colour;
            end
        end
    end

    // Output and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pt_ack_q    <= 1'b0;
            rd_issue_q  <= 1'b0;
            rd_wait_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pt_ack_q    <= pt_ack_d;
            rd_issue_q  <= rd_issue_d;
            rd_wait_q   <= rd_wait_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pt_ack    = pt_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_canvas_mem_arbiter.sv
// tb_canvas_mem_arbiter: directed plus randomized stimulus against a
// transaction-level model of the canvas arbiter and a behavioural RAM.
module tb_canvas_mem_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 3;
    localparam int unsigned DEPTH  = 256;
`ifdef CANVAS_CLEAR_EN
    localparam bit CLR_ON = 1'b1;
`else
    localparam bit CLR_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              pt_req = 1'b0;
    logic [ADDR_W-1:0] pt_addr = '0;
    logic [DATA_W-1:0] pt_colour = '0;
    logic              pt_enable = 1'b0;
    logic              pt_ack;
    logic              clr_start = 1'b0;
    logic              clr_busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    canvas_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .pt_req(pt_req), .pt_addr(pt_addr), .pt_colour(pt_colour),
        .pt_enable(pt_enable), .pt_ack(pt_ack),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous single-port RAM macro
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: canvas contents, clear progress, handshake, read queue
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              m_busy, m_ack;
    logic [ADDR_W-1:0] m_ptr;
    logic              p_v0, p_v1;
    logic [DATA_W-1:0] p_d0, p_d1;
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    int                stolen;
    logic              e_en, e_we, e_ack, e_rv, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_rd;

    task automatic model_reset();
        m_busy = 1'b0; m_ack = 1'b0; m_ptr = '0;
        p_v0 = 1'b0; p_v1 = 1'b0; pend_we = 1'b0;
    endtask

    // Predict DUT outputs after the coming edge from the current inputs
    task automatic model_edge();
        logic was_busy;
        if (pend_we) ref_mem[pend_addr] = pend_data;
        pend_we = 1'b0;
        e_rv = p_v1; e_rd = p_d1;
        p_v1 = p_v0; p_d1 = p_d0;
        p_v0 = rd_req; p_d0 = ref_mem[rd_addr];
        e_en = 1'b0; e_we = 1'b0; e_ack = 1'b0;
        was_busy = m_busy;
        if (rd_req) begin
            e_en = 1'b1; e_addr = rd_addr;
            if (m_busy) stolen++;
        end else if (m_busy) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = m_ptr; e_wdata = '0;
            pend_we = 1'b1; pend_addr = m_ptr; pend_data = '0;
            if (m_ptr == 8'hff) m_busy = 1'b0;
            m_ptr = m_ptr + 8'd1;
        end else if (pt_req && !(CLR_ON && clr_start) && !m_ack) begin
            e_ack = 1'b1;
            if (pt_enable) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = pt_addr; e_wdata = pt_colour;
                pend_we = 1'b1; pend_addr = pt_addr; pend_data = pt_colour;
            end
        end
        if (CLR_ON && !was_busy && clr_start) m_busy = 1'b1;
        m_ack = e_ack;
        e_busy = m_busy;
    endtask

    // Advance one clock and compare every observable output with the model
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        end
        check("pt_ack", 32'(pt_ack), 32'(e_ack));
        check("rd_valid", 32'(rd_valid), 32'(e_rv));
        if (e_rv) check("rd_data", 32'(rd_data), 32'(e_rd));
        check("clr_busy", 32'(clr_busy), 32'(e_busy));
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_pt_ack", 32'(pt_ack), 32'd0);
        check("rst_clr_busy", 32'(clr_busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_in();
        rd_req = 1'b0; pt_req = 1'b0; clr_start = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        idle_in();
        repeat (n) step();
    endtask

    initial begin
        int acks;
        int busy_cnt;
        int bad;
        int scanned;
        logic ack_seen, ack_busy;
        logic [DATA_W-1:0] saved [DEPTH];

        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i] = 3'($urandom_range(0, 7));
            ref_mem[i] = ram[i];
        end
        stolen = 0;
        idle_in();
        #2;
        apply_reset(2);

        // Read returns RAM contents two cycles after the request
        ram[8'h12] = 3'b101; ref_mem[8'h12] = 3'b101;
        rd_req = 1'b1; rd_addr = 8'h12;
        step();
        check("rd_mem_en", 32'(mem_en), 32'd1);
        rd_req = 1'b0;
        step();
        check("rd_early", 32'(rd_valid), 32'd0);
        step();
        check("rd_valid_k2", 32'(rd_valid), 32'd1);
        check("rd_data_12", 32'(rd_data), 32'b101);
        step();
        check("rd_valid_pulse", 32'(rd_valid), 32'd0);

        // Paint write, then read back
        pt_req = 1'b1; pt_addr = 8'h21; pt_colour = 3'b110; pt_enable = 1'b1;
        step();
        check("pt_ack_hi", 32'(pt_ack), 32'd1);
        pt_req = 1'b0;
        step();
        check("pt_ack_pulse", 32'(pt_ack), 32'd0);
        check("ram_21", 32'(ram[8'h21]), 32'b110);
        rd_req = 1'b1; rd_addr = 8'h21;
        step();
        rd_req = 1'b0;
        step(); step();
        check("rd_data_21", 32'(rd_data), 32'b110);

        // Paint with enable low: ack but no RAM access
        pt_req = 1'b1; pt_addr = 8'h21; pt_colour = 3'b011; pt_enable = 1'b0;
        step();
        check("move_ack", 32'(pt_ack), 32'd1);
        check("move_no_en", 32'(mem_en), 32'd0);
        pt_req = 1'b0;
        idle_steps(2);
        check("move_ram_21", 32'(ram[8'h21]), 32'b110);

        // Read and paint on the same edge: read first, ack one cycle later
        rd_req = 1'b1; rd_addr = 8'h40;
        pt_req = 1'b1; pt_addr = 8'h33; pt_colour = 3'b010; pt_enable = 1'b1;
        step();
        check("cont_no_ack", 32'(pt_ack), 32'd0);
        check("cont_read_we", 32'(mem_we), 32'd0);
        rd_req = 1'b0;
        step();
        check("cont_ack", 32'(pt_ack), 32'd1);
        pt_req = 1'b0;
        idle_steps(3);

        // Continuous reads starve paint
        acks = 0;
        pt_req = 1'b1; pt_addr = 8'h34; pt_colour = 3'b001; pt_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_req = 1'b1; rd_addr = 8'($urandom_range(0, 255));
            step();
            if (pt_ack) acks++;
        end
        check("starve_acks", 32'(acks), 32'd0);
        rd_req = 1'b0;
        step();
        check("starve_release_ack", 32'(pt_ack), 32'd1);
        pt_req = 1'b0;
        idle_steps(3);

`ifdef CANVAS_CLEAR_EN
        // Clear with a read every 4th cycle and a paint waiting throughout
        stolen = 0; ack_seen = 1'b0; ack_busy = 1'b0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check("clr_rise", 32'(clr_busy), 32'd1);
        busy_cnt = clr_busy ? 1 : 0;
        pt_req = 1'b1; pt_addr = 8'h05; pt_colour = 3'b111; pt_enable = 1'b1;
        for (int i = 0; i < 600 && !ack_seen; i++) begin
            rd_req = ((i % 4) == 3);
            rd_addr = 8'($urandom_range(0, 255));
            clr_start = (i == 100);
            step();
            if (clr_busy) busy_cnt++;
            if (pt_ack) begin
                ack_seen = 1'b1;
                if (clr_busy) ack_busy = 1'b1;
                pt_req = 1'b0;
            end
        end
        check("clr_ack_seen", 32'(ack_seen), 32'd1);
        check("clr_ack_after_busy", 32'(ack_busy), 32'd0);
        check("clr_len", 32'(busy_cnt), 32'(256 + stolen));
        idle_steps(2);

        // Whole canvas reads zero except the paint that followed the clear
        bad = 0; scanned = 0;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            rd_req = (i < int'(DEPTH));
            rd_addr = 8'(i);
            step();
            if (rd_valid) begin
                if (rd_data != ((scanned == 5) ? 3'b111 : 3'b000)) bad++;
                scanned++;
            end
        end
        check("clr_scan_cnt", 32'(scanned), 32'd256);
        check("clr_scan_bad", 32'(bad), 32'd0);
        idle_steps(2);

        // Reset in the middle of a clear aborts it for good
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i] = 3'($urandom_range(1, 7));
            ref_mem[i] = ram[i];
            saved[i] = ram[i];
        end
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 400 && m_ptr != 8'h40; i++) step();
        check("abort_ptr_reached", 32'(m_ptr), 32'h40);
        apply_reset(2);
        idle_steps(5);
        check("abort_busy", 32'(clr_busy), 32'd0);
        bad = 0;
        for (int i = 8'h40; i < int'(DEPTH); i++) if (ram[i] != saved[i]) bad++;
        check("abort_upper_kept", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 8'h3f; i++) if (ram[i] != 3'b000) bad++;
        check("abort_lower_zero", 32'(bad), 32'd0);
`endif

        // Randomized traffic with a well-behaved paint requester
        idle_in();
        for (int i = 0; i < 3000; i++) begin
            if (pt_ack) begin
                pt_req = 1'b0;
            end else if (!pt_req && $urandom_range(0, 3) == 0) begin
                pt_req = 1'b1;
                pt_addr = 8'($urandom_range(0, 255));
                pt_colour = 3'($urandom_range(0, 7));
                pt_enable = ($urandom_range(0, 3) != 0);
            end
            rd_req = ($urandom_range(0, 2) == 0);
            rd_addr = 8'($urandom_range(0, 255));
            clr_start = ($urandom_range(0, 999) == 0);
            step();
        end
        idle_in();
        for (int i = 0; i < 600 && (clr_busy || pt_ack); i++) step();
        idle_steps(3);
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== ref_mem[i]) bad++;
        check("ram_final", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
